// File: rtl/sccb_pkg.sv
// Shared SCCB definitions for the responder, master and clock divider.
// FSM state encoding, phase length and default camera IDs.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ID     = 3'd1,
    ST_SUB    = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } sccb_state_e;

  localparam int         SCCB_BITS_PER_PHASE = 9;
  localparam logic [7:0] SCCB_OV_WR_ID       = 8'h42;
  localparam logic [7:0] SCCB_OV_RD_ID       = 8'h43;

  function automatic logic [7:0] sccb_rd_id(input logic [7:0] wr_id);
    return {wr_id[7:1], 1'b1};
  endfunction

endpackage

// File: rtl/sccb_responder_if.sv
// SCCB responder bus + register-port bundle; slave = responder view, master = driver/bench view.
interface sccb_responder_if;
  logic       sioc_i;
  logic       siod_i;
  logic       siod_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  sioc_i, siod_i, reg_rdata,
    output siod_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output sioc_i, siod_i, reg_rdata,
    input  siod_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/sccb_line_sync.sv
// Synchronizes SIO_C/SIO_D into the refclk domain and decodes clock edges and start/stop.
// Events are valid SYNC_STAGES+1 cycles after the bus edge; start/stop mask any coincident edge.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic sioc_i,
  input  logic siod_i,
  output logic sc_rise_o,
  output logic sc_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sd_o
);

  logic [SYNC_STAGES-1:0] sc_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   sc_hist_q;
  logic                   sd_hist_q;
  logic                   sc_lvl;
  logic                   sd_lvl;
  logic                   start_c;
  logic                   stop_c;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sc_sync_q <= '1;
      sd_sync_q <= '1;
      sc_hist_q <= 1'b1;
      sd_hist_q <= 1'b1;
    end else begin
      sc_sync_q <= {sc_sync_q[SYNC_STAGES-2:0], sioc_i};
      sd_sync_q <= {sd_sync_q[SYNC_STAGES-2:0], siod_i};
      sc_hist_q <= sc_lvl;
      sd_hist_q <= sd_lvl;
    end
  end

  assign sc_lvl  = sc_sync_q[SYNC_STAGES-1];
  assign sd_lvl  = sd_sync_q[SYNC_STAGES-1];
  assign start_c = sc_lvl & sc_hist_q & sd_hist_q & ~sd_lvl;
  assign stop_c  = sc_lvl & sc_hist_q & ~sd_hist_q & sd_lvl;

  assign start_o   = start_c;
  assign stop_o    = stop_c;
  assign sc_rise_o = sc_lvl & ~sc_hist_q & ~start_c & ~stop_c;
  assign sc_fall_o = ~sc_lvl & sc_hist_q & ~start_c & ~stop_c;
  assign sd_o      = sd_lvl;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes 3-phase/2-phase writes and 2-phase reads into a register strobe port.
// Phase decisions happen on the 8th sc_rise; SIO_D output only moves on sc_fall or start/stop.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = SCCB_OV_WR_ID,
  parameter int         SYNC_STAGES = 2,
  parameter int         ACK_EN      = 1
) (
  input logic              refclk,
  input logic              rstn,
  sccb_responder_if.slave  bus
);

  localparam logic [7:0] WR_ID     = {DEVICE_ID[7:1], 1'b0};
  localparam logic [7:0] RD_ID     = sccb_rd_id(WR_ID);
  localparam logic [3:0] LAST_SLOT = 4'(SCCB_BITS_PER_PHASE - 1);
  localparam logic [3:0] BYTE_DONE = 4'(SCCB_BITS_PER_PHASE - 2);
  localparam logic       ACK_ON    = (ACK_EN != 0);

  logic        ev_rise, ev_fall, ev_start, ev_stop, sd;
  sccb_state_e state_q;
  logic [3:0]  bitcnt_q;
  logic [7:0]  shift_q, rdata_q, reg_addr_q, reg_wdata_q;
  logic        ack_q, oe_q, busy_q, reg_we_q, reg_re_q, re_d1_q;
  logic [7:0]  byte_c;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i     (refclk),
    .rstn_i    (rstn),
    .sioc_i    (bus.sioc_i),
    .siod_i    (bus.siod_i),
    .sc_rise_o (ev_rise),
    .sc_fall_o (ev_fall),
    .start_o   (ev_start),
    .stop_o    (ev_stop),
    .sd_o      (sd)
  );

  assign byte_c = {shift_q[6:0], sd};

  always_ff @(posedge refclk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      ack_q       <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      re_d1_q     <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      re_d1_q  <= reg_re_q;
      // Register file returns read data two cycles after the request.
      if (re_d1_q) rdata_q <= bus.reg_rdata;

      if (ev_stop) begin
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        oe_q     <= 1'b0;
        bitcnt_q <= '0;
        ack_q    <= 1'b0;
      end else if (ev_start) begin
        state_q  <= ST_ID;
        busy_q   <= 1'b1;
        oe_q     <= 1'b0;
        bitcnt_q <= '0;
        ack_q    <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (ev_rise) begin
          if (bitcnt_q == LAST_SLOT) begin
            bitcnt_q <= '0;
            ack_q    <= 1'b0;
          end else begin
            shift_q  <= byte_c;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == BYTE_DONE) begin
              // Next state is taken now; the following slot is this phase's ACK/NA.
              ack_q <= 1'b0;
              case (state_q)
                ST_ID: begin
                  if (byte_c == WR_ID) begin
                    state_q <= ST_SUB;
                    ack_q   <= ACK_ON;
                  end else if (byte_c == RD_ID) begin
                    state_q  <= ST_RDATA;
                    reg_re_q <= 1'b1;
                    ack_q    <= ACK_ON;
                  end else begin
                    state_q <= ST_IGNORE;
                  end
                end
                ST_SUB: begin
                  reg_addr_q <= byte_c;
                  state_q    <= ST_WDATA;
                  ack_q      <= ACK_ON;
                end
                ST_WDATA: begin
                  reg_wdata_q <= byte_c;
                  reg_we_q    <= 1'b1;
                  state_q     <= ST_IGNORE;
                  ack_q       <= ACK_ON;
                end
                ST_RDATA: state_q <= ST_IGNORE;
                default:  state_q <= state_q;
              endcase
            end
          end
        end else if (ev_fall) begin
          if (bitcnt_q == LAST_SLOT) begin
            oe_q <= ack_q;
          end else if (state_q == ST_RDATA) begin
            oe_q <= ~rdata_q[3'd7 - bitcnt_q[2:0]];
          end else begin
            oe_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.siod_oe   = oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench: acts as the SCCB master with an open-drain SIO_D and checks strobes, ACK and read data.
module tb_sccb_responder;

  localparam time Q = 40;

  logic refclk = 1'b0;
  logic rstn   = 1'b0;
  logic scl_m  = 1'b1;
  logic sda_m  = 1'b1;

  int tests = 0;
  int fails = 0;

  int         we_cnt  = 0;
  int         we_run  = 0;
  int         we_maxw = 0;
  int         re_cnt  = 0;
  logic [7:0] we_addr = 8'h00;
  logic [7:0] we_data = 8'h00;
  logic [7:0] re_addr = 8'h00;

  logic       a;
  logic [7:0] d;

  sccb_responder_if bus();

  assign bus.sioc_i    = scl_m;
  assign bus.siod_i    = sda_m & ~bus.siod_oe;
  assign bus.reg_rdata = 8'h76;

  sccb_responder #(
    .DEVICE_ID   (8'h42),
    .SYNC_STAGES (2),
    .ACK_EN      (1)
  ) dut (
    .refclk (refclk),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  always @(negedge refclk) begin
    if (bus.reg_we) begin
      we_run = we_run + 1;
      if (we_run == 1) begin
        we_cnt  = we_cnt + 1;
        we_addr = bus.reg_addr;
        we_data = bus.reg_wdata;
      end
      if (we_run > we_maxw) we_maxw = we_run;
    end else begin
      we_run = 0;
    end
    if (bus.reg_re) begin
      re_cnt  = re_cnt + 1;
      re_addr = bus.reg_addr;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i];
      #Q scl_m = 1'b1;
      #(2*Q) scl_m = 1'b0;
      #Q;
    end
  endtask

  task automatic ack_slot(output logic oe);
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q oe = bus.siod_oe;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    bits(b, 8);
    ack_slot(ack);
  endtask

  task automatic rbyte(output logic [7:0] dat, output logic na_oe);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q scl_m = 1'b1;
      #Q dat[i] = bus.siod_i;
      #Q scl_m = 1'b0;
      #Q;
    end
    ack_slot(na_oe);
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
    #Q;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_oe",    bus.siod_oe,   0);
    chk("rst_we",    bus.reg_we,    0);
    chk("rst_re",    bus.reg_re,    0);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_addr",  bus.reg_addr,  0);
    chk("rst_wdata", bus.reg_wdata, 0);
    @(negedge refclk);
    rstn = 1'b1;
    repeat (4) @(negedge refclk);

    // 3-phase write 0x42 / 0x12 / 0x80
    start_c();
    chk("w3_busy", bus.busy, 1);
    wbyte(8'h42, a); chk("w3_ack_id", a, 1);
    wbyte(8'h12, a); chk("w3_ack_sub", a, 1);
    wbyte(8'h80, a); chk("w3_ack_data", a, 1);
    chk("w3_we_cnt", we_cnt, 1);
    chk("w3_we_addr", we_addr, 8'h12);
    chk("w3_we_data", we_data, 8'h80);
    chk("w3_we_width", we_maxw, 1);
    stop_c();
    chk("w3_busy_stop", bus.busy, 0);

    // 2-phase write sets the pointer, then a 2-phase read
    start_c();
    wbyte(8'h42, a); chk("w2_ack_id", a, 1);
    wbyte(8'h0A, a); chk("w2_ack_sub", a, 1);
    stop_c();
    chk("w2_addr", bus.reg_addr, 8'h0A);
    chk("w2_no_we", we_cnt, 1);
    start_c();
    wbyte(8'h43, a); chk("rd_ack_id", a, 1);
    chk("rd_re_cnt", re_cnt, 1);
    chk("rd_re_addr", re_addr, 8'h0A);
    rbyte(d, a);
    chk("rd_data", d, 8'h76);
    chk("rd_na_oe", a, 0);
    stop_c();
    chk("rd_busy_stop", bus.busy, 0);

    // Wrong ID is ignored until stop
    start_c();
    wbyte(8'h60, a); chk("bad_ack_id", a, 0);
    wbyte(8'h12, a); chk("bad_ack_next", a, 0);
    chk("bad_busy", bus.busy, 1);
    chk("bad_no_we", we_cnt, 1);
    chk("bad_no_re", re_cnt, 1);
    stop_c();
    chk("bad_busy_stop", bus.busy, 0);

    // Stop after the 4th bit of the sub-address phase
    start_c();
    wbyte(8'h42, a); chk("ab_ack_id", a, 1);
    bits(8'h55, 4);
    stop_c();
    chk("ab_busy", bus.busy, 0);
    chk("ab_addr", bus.reg_addr, 8'h0A);
    chk("ab_no_we", we_cnt, 1);

    // Repeated start during the data phase, then a read
    start_c();
    wbyte(8'h42, a); chk("rs_ack_id", a, 1);
    wbyte(8'h33, a); chk("rs_ack_sub", a, 1);
    bits(8'h99, 3);
    start_c();
    chk("rs_busy", bus.busy, 1);
    wbyte(8'h43, a); chk("rs_ack_rd", a, 1);
    chk("rs_re_cnt", re_cnt, 2);
    chk("rs_re_addr", re_addr, 8'h33);
    rbyte(d, a);
    chk("rs_data", d, 8'h76);
    chk("rs_na_oe", a, 0);
    chk("rs_no_we", we_cnt, 1);
    stop_c();

    // Reset while the responder is pulling SIO_D low during a read
    start_c();
    wbyte(8'h43, a); chk("rr_ack_id", a, 1);
    chk("rr_oe_before", bus.siod_oe, 1);
    @(negedge refclk);
    rstn = 1'b0;
    @(posedge refclk);
    #1;
    chk("rr_oe_after", bus.siod_oe, 0);
    chk("rr_busy_after", bus.busy, 0);
    @(negedge refclk);
    rstn = 1'b1;
    stop_c();
    chk("rr_addr_cleared", bus.reg_addr, 0);
    chk("rr_busy_final", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB target (responder) paired with the camera-side SCCB master, which is clocked by the team's SCCB clock divider.
- Oversamples SIO_C/SIO_D in the refclk domain and decodes 3-phase writes, 2-phase writes and 2-phase reads.
- Presents a simple register-port strobe interface to a local register file.
- Used as the bench camera model and as the config target in loopback builds.

Parameters:
- DEVICE_ID, 8'h42: write ID; the read ID is DEVICE_ID|1. Bit 0 of the parameter is ignored.
- SYNC_STAGES, 2: synchronizer depth on sioc_i/siod_i, minimum 2.
- ACK_EN, 1: when 1, drive low in the 9th-bit slot of accepted phases; when 0, never drive the 9th bit.

Ports:
- refclk  in  1  system clock, must be ≥ 8× the SIO_C frequency.
- rstn  in  1  synchronous active-low reset, sampled on the refclk rising edge.
- sioc_i  in  1  SIO_C bus level.
- siod_i  in  1  SIO_D bus level.
- siod_oe  out  1  1 = pull SIO_D low (open drain); the pad ties the output to 0.
- reg_addr  out  8  sub-address pointer.
- reg_wdata  out  8  write data, valid while reg_we = 1.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read request.
- reg_rdata  in  8  read data, sampled exactly 2 cycles after reg_re.
- busy  out  1  1 from an accepted start until stop.

Behaviour:
- Reset (rstn = 0 at a clock edge):
  - siod_oe = 0, reg_we = 0, reg_re = 0, busy = 0, reg_addr = 0, reg_wdata = 0.
  - State = IDLE, synchronizer flops = 1.
  - Reset mid-transaction releases SIO_D on the next edge.
- Synchronizer and edge detection:
  - Both lines pass through SYNC_STAGES flops, plus one history flop.
  - Events:
    - sc_rise / sc_fall: SIO_C edges.
    - start: SIO_D falling while SIO_C = 1.
    - stop: SIO_D rising while SIO_C = 1.
  - Event latency is SYNC_STAGES+1 refclk cycles after the bus edge.
  - If start or stop coincides with any other event, start/stop wins.
- Bit handling:
  - Data bits are shifted MSB first on sc_rise. bitcnt runs 0..8; bit 8 is the 9th (ACK/NA) slot.
  - Responder output changes only on sc_fall.
- FSM states: IDLE, ID, SUB, WDATA, RDATA, IGNORE.
  - IDLE: on start, go to ID, set busy = 1.
  - ID:
    - After 8 bits, if byte == DEVICE_ID with LSB 0, go to SUB.
    - If byte == DEVICE_ID with LSB 1, pulse reg_re with the current reg_addr, then go to RDATA.
    - Otherwise go to IGNORE with no ACK.
  - SUB: after 8 bits, load reg_addr and go to WDATA. A stop here completes a 2-phase write (address set only).
  - WDATA: after 8 bits, set reg_wdata and pulse reg_we for 1 cycle on the 8th sc_rise + 1 cycle, then go to IGNORE. Extra bytes are ignored and not acked.
  - RDATA:
    - Capture reg_rdata 2 cycles after reg_re.
    - On each sc_fall, drive siod_oe = ~bit[7-bitcnt].
    - In the 9th slot, siod_oe = 0 (master NA); then go to IGNORE.
  - IGNORE: siod_oe = 0; wait for stop.
- ACK (ACK_EN = 1, phase accepted):
  - siod_oe = 1 from the sc_fall after the 8th bit until the sc_fall after the 9th bit.
- Global rules:
  - stop in any state: go to IDLE, busy = 0, siod_oe = 0 on the same cycle.
  - Repeated start in any state: go to ID, bitcnt = 0, siod_oe = 0.
  - reg_addr persists across transactions, with no auto-increment.
  - siod_oe never changes while the synchronized SIO_C = 1, except on a stop/start release.

Decomposition:
- Shared package sccb_pkg:
  - State encoding localparams.
  - SCCB_BITS_PER_PHASE = 9.
  - Default IDs: OV write ID 8'h42 / read ID 8'h43.
  - Shared with the master and the clock divider.
- Sub-module sccb_line_sync: synchronizer, history flops, and the sc_rise/sc_fall/start/stop event decode.

Test Plan:
- 3-phase write: ID 0x42, sub 0x12, data 0x80 → reg_we = 1 for one cycle with reg_addr = 0x12 and reg_wdata = 0x80; ACK low in all three 9th slots.
- 2-phase write then read: write ID 0x42, sub 0x0A, stop; then ID 0x43 with reg_rdata = 0x76 → reg_re pulses with reg_addr = 0x0A; SIO_D carries 0x76 MSB first; siod_oe = 0 in the NA slot.
- Wrong ID 0x60 → no ACK, no strobes, busy stays 1 until stop.
- Stop after the 4th bit of the sub phase → IDLE, busy = 0, reg_addr unchanged, no reg_we.
- Repeated start during WDATA, then ID 0x43 → read path taken; no reg_we from the aborted write.
- rstn = 0 while siod_oe = 1 during a read → siod_oe = 0 and busy = 0 at the next refclk edge.
